// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-input, W-bit registered stream multiplexer.
// A combinational arbiter picks one valid producer per cycle and loads its
// word into a single output register under valid/ready flow control.
// Build option: define RR_STREAM_MUX_FIXED_PRIO_EN for fixed lowest-index
// priority.  Without it (the default) the arbiter is round-robin.
//
// Handshake: a word moves on any channel in a cycle where both valid and
// ready are high at the rising edge of clk.  The block never withdraws a
// ready it has raised within a cycle.  Producers keep in_data stable while
// in_valid is high and they have not been granted.
module rr_stream_mux #(
   parameter int INS   = 5,
   parameter int WIDTH = 8,
   parameter int SELW  = $clog2(INS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INS*WIDTH-1:0] in_data,
   input  logic [INS-1:0]       in_valid,
   output logic [INS-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] out_data_q;
   logic [SELW-1:0]  out_sel_q;
   logic             out_valid_q;

   logic             can_load;
   logic             grant_found;
   logic [SELW-1:0]  grant_idx;
   logic             take;

`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
   logic [SELW-1:0]  last_grant_q;

   // Channel index 'off' positions after 'base', wrapping at INS-1 back to 0.
   function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base,
                                                input int              off);
      int s;
      s = int'(base) + off;
      if (s >= INS) s = s - INS;
      return SELW'(s);
   endfunction
`endif

   // The stage accepts a new word when it is empty or draining this cycle.
   assign can_load = !out_valid_q || out_ready;

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
   // Fixed priority: scan from the top down so the lowest valid index wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = INS - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = SELW'(i);
         end
      end
   end
`else
   // Round-robin: scan offsets INS..1 from the last grant so the smallest
   // offset with a valid channel is the one left standing.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = INS; i >= 1; i--) begin
         if (in_valid[wrap_idx(last_grant_q, i)]) begin
            grant_found = 1'b1;
            grant_idx   = wrap_idx(last_grant_q, i);
         end
      end
   end
`endif

   assign take = grant_found && can_load;

   // Ready is one-hot on the granted channel, and only when the stage can load.
   always_comb begin
      in_ready = '0;
      if (take) in_ready[grant_idx] = 1'b1;
   end

   // Output register: load on an input transfer, clear valid on a bare drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else if (take) begin
         out_valid_q <= 1'b1;
         out_data_q  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_sel_q   <= grant_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
   // Last-grant pointer moves only on an input transfer; reset makes ch0 first.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= SELW'(INS - 1);
      end else if (take) begin
         last_grant_q <= grant_idx;
      end
   end
`endif

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule
